imem_fetch_router: RTL and testbench
====================================

// Module: imem_fetch_router
// PURPOSE
//  Next-generation instruction-side memory controller between fetch and the ITCM/instruction bus.
//  Decodes each fetch address to ITCM, bus or (optionally) fault, and keeps up to MAX_OUTSTANDING requests in flight.
//  Returns responses in order and discards stale responses after a fetch flush (branch/trap redirect).
// PARAMETERS
//  ADDR_W           32           address width
//  DATA_W           32           instruction word width
//  ITCM_BASE        32'h0000_0000  ITCM window base
//  ITCM_SIZE        32'h0001_0000  ITCM window size, bytes
//  BUS_BASE         32'h0001_0000  bus window base (used only with the fault feature)
//  BUS_SIZE         32'hFFFF_0000  bus window size, bytes
//  MAX_OUTSTANDING  4            in-flight request limit; power of 2, >=2
// PORTS
//  cpu_clk      in   1       cpu clock
//  cpu_rst      in   1       synchronous reset, active high
//  fetch_req    in   1       fetch request valid
//  fetch_addr   in   ADDR_W  fetch address, word aligned
//  fetch_gnt    out  1       request accepted this cycle (fire = fetch_req & fetch_gnt)
//  fetch_flush  in   1       discard all responses for requests accepted before this cycle
//  fetch_rdata  out  DATA_W  instruction
//  fetch_rvalid out  1       instruction valid
//  fetch_rerr   out  1       access fault (constant 0 without IMEM_ACCESS_FAULT_EN)
//  itcm_req     out  1       ITCM read request
//  itcm_addr    out  ADDR_W  ITCM address
//  itcm_busy    in   1       ITCM auto-load in progress; no ITCM accepts
//  itcm_rdata   in   DATA_W  ITCM data, fixed 1-cycle latency
//  itcm_rvalid  in   1       ITCM data valid
//  ibus_req     out  1       bus read request
//  ibus_addr    out  ADDR_W  bus address
//  ibus_gnt     in   1       bus accepted request
//  ibus_rdata   in   DATA_W  bus data
//  ibus_rvalid  in   1       bus data valid, in-order, variable latency
// BEHAVIOUR
//  - Reset: all outputs 0; out_cnt=0, disc_cnt=0, cur_src=ITCM.
//  - Decode (comb.): ITCM if ITCM_BASE<=addr<ITCM_BASE+ITCM_SIZE, else BUS (else FAULT, see CONFIGURATION).
//  - stall = (out_cnt==MAX_OUTSTANDING) | (out_cnt!=0 & tgt!=cur_src) | (tgt==ITCM & itcm_busy).
//  - itcm_req = fetch_req & tgt==ITCM & !stall; fetch_gnt = itcm_req for ITCM targets.
//  - ibus_req = fetch_req & tgt==BUS & !stall; fetch_gnt = ibus_req & ibus_gnt for bus targets.
//  - *_addr = fetch_addr, combinational pass-through. Zero added request latency.
//  - On fire: cur_src<=tgt. Source switch drains the old source first, so the order is preserved without tags.
//  - resp = selected source rvalid (cur_src) while out_cnt!=0. rvalid with out_cnt==0 is ignored.
//  - out_cnt += fire - resp. Simultaneous fire and resp leaves it unchanged.
//  - disc_cnt>0: resp is dropped (fetch_rvalid=0) and disc_cnt decrements.
//  - fetch_flush: disc_cnt <= out_cnt - resp (in-flight old requests).
//    - A resp arriving in the flush cycle is dropped.
//    - A fire in the flush cycle is new-path and is not discarded.
//  - fetch_rvalid = resp & disc_cnt==0 & !fetch_flush; fetch_rdata = rdata when valid, else 0.
//  - Reset mid-operation: counters clear. Late bus rvalid after reset is ignored (out_cnt==0).
//  - Widths: out_cnt/disc_cnt are $clog2(MAX_OUTSTANDING+1) bits; never wrap (stall at MAX).
// CONFIGURATION
//  IMEM_ACCESS_FAULT_EN defined:
//    - Addresses in neither window decode to FAULT and are accepted with no itcm/ibus request.
//    - Response next cycle: fetch_rvalid=1, fetch_rerr=1, fetch_rdata=0, subject to the flush rules.
//    - FAULT counts as its own source for the drain rule.
//  Undefined: every non-ITCM address goes to BUS; fetch_rerr tied 0; BUS_BASE/BUS_SIZE unused.
// STRUCTURE
//  - imem_pkg: source encoding (SRC_ITCM/SRC_BUS/SRC_FAULT), default window constants, counter-width function.
//  - One sub-module: imem_addr_decode (comb. window compare -> target); the top holds counters and muxing.
// TESTING
//  1. ITCM back-to-back 0x0,0x4,0x8, no stall -> gnt each cycle; rdata returned 1 cycle later, in order.
//  2. Bus at 0x2_0000, ibus_gnt=1, rvalid delayed 3 cycles, 5 requests -> 5th stalled at out_cnt=4;
//     gnt resumes the cycle after the first rvalid.
//  3. Bus request in flight, then ITCM request at 0x10 -> fetch_gnt=0 until bus rvalid; then ITCM accepted.
//  4. 3 bus requests outstanding, fetch_flush with a new req to 0x2_0100 -> 3 old rvalids dropped; 4th delivered.
//  5. itcm_busy=1, ITCM request -> no itcm_req/gnt; accepted the cycle busy drops.
//  6. With IMEM_ACCESS_FAULT_EN, fetch 0xFFFF_FFF0 when outside both windows -> no ibus_req;
//     next cycle rvalid=1, rerr=1, rdata=0.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: source encoding, default address windows and the counter-width helper
// shared by the instruction fetch router and its address decoder.
package imem_pkg;

   // Where a fetch is routed; FAULT exists only when the access-fault feature is built.
   typedef enum logic [1:0] {
      SRC_ITCM  = 2'd0,
      SRC_BUS   = 2'd1,
      SRC_FAULT = 2'd2
   } src_e;

   localparam logic [31:0] ITCM_BASE_DEF = 32'h0000_0000;
   localparam logic [31:0] ITCM_SIZE_DEF = 32'h0001_0000;
   localparam logic [31:0] BUS_BASE_DEF  = 32'h0001_0000;
   localparam logic [31:0] BUS_SIZE_DEF  = 32'hFFFF_0000;

   // Bits needed to count 0..max_out inclusive.
   function automatic int cnt_w(input int max_out);
      return $clog2(max_out + 1);
   endfunction

endpackage

// File: rtl/imem_addr_decode.sv
// imem_addr_decode: combinational window compare that maps a fetch address to
// its target source. Offsets are compared instead of end addresses so a window
// reaching the top of the address space does not overflow.
module imem_addr_decode
   import imem_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] ITCM_BASE = ADDR_W'(ITCM_BASE_DEF),
   parameter logic [ADDR_W-1:0] ITCM_SIZE = ADDR_W'(ITCM_SIZE_DEF),
   parameter logic [ADDR_W-1:0] BUS_BASE  = ADDR_W'(BUS_BASE_DEF),
   parameter logic [ADDR_W-1:0] BUS_SIZE  = ADDR_W'(BUS_SIZE_DEF),
   parameter bit                FAULT_EN  = 1'b0
) (
   input  logic [ADDR_W-1:0] addr,
   output src_e              tgt
);

   logic [ADDR_W-1:0] itcm_off;
   logic [ADDR_W-1:0] bus_off;
   logic              in_itcm;
   logic              in_bus;

   // Window membership and target selection; without the fault feature every
   // non-ITCM address is sent to the bus.
   always_comb begin
      itcm_off = addr - ITCM_BASE;
      bus_off  = addr - BUS_BASE;
      in_itcm  = (addr >= ITCM_BASE) && (itcm_off < ITCM_SIZE);
      in_bus   = (addr >= BUS_BASE) && (bus_off < BUS_SIZE);
      if (in_itcm) begin
         tgt = SRC_ITCM;
      end else if (!FAULT_EN || in_bus) begin
         tgt = SRC_BUS;
      end else begin
         tgt = SRC_FAULT;
      end
   end

endmodule

// File: rtl/imem_fetch_router.sv
// imem_fetch_router: routes instruction fetches to ITCM or the instruction bus,
// tracks up to MAX_OUTSTANDING in-flight requests and returns responses in order.
// Order is kept without tags by draining one source before switching to another.
// After a flush, responses still owed for older requests are counted and dropped.
// Optional feature macro: IMEM_ACCESS_FAULT_EN (out-of-window fetches answer with rerr).
module imem_fetch_router
   import imem_pkg::*;
#(
   parameter int                ADDR_W          = 32,
   parameter int                DATA_W          = 32,
   parameter logic [ADDR_W-1:0] ITCM_BASE       = ADDR_W'(ITCM_BASE_DEF),
   parameter logic [ADDR_W-1:0] ITCM_SIZE       = ADDR_W'(ITCM_SIZE_DEF),
   parameter logic [ADDR_W-1:0] BUS_BASE        = ADDR_W'(BUS_BASE_DEF),
   parameter logic [ADDR_W-1:0] BUS_SIZE        = ADDR_W'(BUS_SIZE_DEF),
   parameter int                MAX_OUTSTANDING = 4
) (
   input  logic              cpu_clk,
   input  logic              cpu_rst,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   input  logic              fetch_flush,
   output logic [DATA_W-1:0] fetch_rdata,
   output logic              fetch_rvalid,
   output logic              fetch_rerr,
   output logic              itcm_req,
   output logic [ADDR_W-1:0] itcm_addr,
   input  logic              itcm_busy,
   input  logic [DATA_W-1:0] itcm_rdata,
   input  logic              itcm_rvalid,
   output logic              ibus_req,
   output logic [ADDR_W-1:0] ibus_addr,
   input  logic              ibus_gnt,
   input  logic [DATA_W-1:0] ibus_rdata,
   input  logic              ibus_rvalid
);

   localparam int            CW      = cnt_w(MAX_OUTSTANDING);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
   localparam logic [CW-1:0] ZERO    = {CW{1'b0}};
`ifdef IMEM_ACCESS_FAULT_EN
   localparam bit            FAULT_EN = 1'b1;
`else
   localparam bit            FAULT_EN = 1'b0;
`endif

   src_e              tgt;
   src_e              cur_src_q, cur_src_d;
   logic [CW-1:0]     out_cnt_q, out_cnt_d;
   logic [CW-1:0]     disc_cnt_q, disc_cnt_d;
   logic              fault_v_q, fault_v_d;
   logic              stall;
   logic              fault_fire;
   logic              fire;
   logic              resp;
   logic              src_rvalid;
   logic [DATA_W-1:0] src_rdata;

   imem_addr_decode #(
      .ADDR_W    (ADDR_W),
      .ITCM_BASE (ITCM_BASE),
      .ITCM_SIZE (ITCM_SIZE),
      .BUS_BASE  (BUS_BASE),
      .BUS_SIZE  (BUS_SIZE),
      .FAULT_EN  (FAULT_EN)
   ) u_decode (
      .addr (fetch_addr),
      .tgt  (tgt)
   );

   // Request gating, response selection and counter next-state; everything is
   // held at zero while reset is asserted.
   always_comb begin
      itcm_addr    = cpu_rst ? {ADDR_W{1'b0}} : fetch_addr;
      ibus_addr    = cpu_rst ? {ADDR_W{1'b0}} : fetch_addr;
      stall        = cpu_rst
                   | (out_cnt_q == MAX_CNT)
                   | ((out_cnt_q != ZERO) & (tgt != cur_src_q))
                   | ((tgt == SRC_ITCM) & itcm_busy);
      itcm_req     = fetch_req & (tgt == SRC_ITCM) & ~stall;
      ibus_req     = fetch_req & (tgt == SRC_BUS) & ~stall;
      fault_fire   = fetch_req & (tgt == SRC_FAULT) & ~stall;
      fire         = itcm_req | (ibus_req & ibus_gnt) | fault_fire;
      fetch_gnt    = fire;

      case (cur_src_q)
         SRC_ITCM: begin
            src_rvalid = itcm_rvalid;
            src_rdata  = itcm_rdata;
         end
         SRC_BUS: begin
            src_rvalid = ibus_rvalid;
            src_rdata  = ibus_rdata;
         end
         SRC_FAULT: begin
            src_rvalid = fault_v_q;
            src_rdata  = {DATA_W{1'b0}};
         end
         default: begin
            src_rvalid = 1'b0;
            src_rdata  = {DATA_W{1'b0}};
         end
      endcase

      // Stray rvalid with nothing in flight (e.g. a late bus beat after reset) is ignored.
      resp         = src_rvalid & (out_cnt_q != ZERO) & ~cpu_rst;
      fetch_rvalid = resp & (disc_cnt_q == ZERO) & ~fetch_flush;
      fetch_rdata  = fetch_rvalid ? src_rdata : {DATA_W{1'b0}};
`ifdef IMEM_ACCESS_FAULT_EN
      fetch_rerr   = fetch_rvalid & (cur_src_q == SRC_FAULT);
`else
      fetch_rerr   = 1'b0;
`endif

      out_cnt_d    = out_cnt_q + CW'(fire) - CW'(resp);
      if (fetch_flush) begin
         // Everything still owed for older requests becomes stale; a fire this cycle is new-path.
         disc_cnt_d = out_cnt_q - CW'(resp);
      end else if (resp && (disc_cnt_q != ZERO)) begin
         disc_cnt_d = disc_cnt_q - CW'(1'b1);
      end else begin
         disc_cnt_d = disc_cnt_q;
      end
      cur_src_d    = fire ? tgt : cur_src_q;
      fault_v_d    = fault_fire;
   end

   // State registers with synchronous reset.
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         out_cnt_q  <= ZERO;
         disc_cnt_q <= ZERO;
         cur_src_q  <= SRC_ITCM;
         fault_v_q  <= 1'b0;
      end else begin
         out_cnt_q  <= out_cnt_d;
         disc_cnt_q <= disc_cnt_d;
         cur_src_q  <= cur_src_d;
         fault_v_q  <= fault_v_d;
      end
   end

endmodule

// File: tb/tb_imem_fetch_router.sv
// tb_imem_fetch_router: table-driven ITCM vectors, directed multi-cycle
// sequences and a randomized phase, all checked against an in-order queue
// model of the in-flight requests. Build with IMEM_ACCESS_FAULT_EN for the
// fault feature (the bench then shrinks the bus window so a fault region exists).
`timescale 1ns/1ps
module tb_imem_fetch_router;

   localparam int          MAXO      = 4;
   localparam logic [31:0] ITCM_BASE = 32'h0000_0000;
   localparam logic [31:0] ITCM_SIZE = 32'h0001_0000;
   localparam logic [31:0] BUS_BASE  = 32'h0001_0000;
`ifdef IMEM_ACCESS_FAULT_EN
   localparam logic [31:0] BUS_SIZE  = 32'h0FFF_0000;
   localparam bit          FAULT_EN  = 1'b1;
`else
   localparam logic [31:0] BUS_SIZE  = 32'hFFFF_0000;
   localparam bit          FAULT_EN  = 1'b0;
`endif

   logic        cpu_clk = 1'b0;
   logic        cpu_rst, fetch_req, fetch_flush, itcm_busy, ibus_gnt;
   logic [31:0] fetch_addr, itcm_rdata, ibus_rdata;
   logic        itcm_rvalid, ibus_rvalid;
   logic        fetch_gnt, fetch_rvalid, fetch_rerr, itcm_req, ibus_req;
   logic [31:0] fetch_rdata, itcm_addr, ibus_addr;

   imem_fetch_router #(
      .ADDR_W(32), .DATA_W(32),
      .ITCM_BASE(ITCM_BASE), .ITCM_SIZE(ITCM_SIZE),
      .BUS_BASE(BUS_BASE), .BUS_SIZE(BUS_SIZE),
      .MAX_OUTSTANDING(MAXO)
   ) dut (
      .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
      .fetch_flush(fetch_flush), .fetch_rdata(fetch_rdata),
      .fetch_rvalid(fetch_rvalid), .fetch_rerr(fetch_rerr),
      .itcm_req(itcm_req), .itcm_addr(itcm_addr), .itcm_busy(itcm_busy),
      .itcm_rdata(itcm_rdata), .itcm_rvalid(itcm_rvalid),
      .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt),
      .ibus_rdata(ibus_rdata), .ibus_rvalid(ibus_rvalid)
   );

   always #5 cpu_clk = ~cpu_clk;

   // Model of in-flight requests: 0 = ITCM, 1 = bus, 2 = fault.
   typedef struct {
      int          src;
      logic [31:0] data;
      bit          err;
      bit          stale;
   } ent_t;
   typedef struct {
      logic [31:0] addr;
      int          due;
   } bus_t;
   typedef struct {
      bit          req;
      logic [31:0] addr;
      bit          busy;
      bit          egnt;
      bit          erv;
      logic [31:0] erd;
   } vec_t;

   ent_t        mq[$];
   bus_t        bq[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_due = -1;
   int          lat_min = 4, lat_max = 4;
   bit          fault_pend = 1'b0;
   bit          itcm_hit;
   logic [31:0] itcm_hit_addr;
   bit          cap_gnt, cap_rv, cap_err, cap_itcm, cap_ibus;
   logic [31:0] cap_rd;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   // Window rule evaluated in 64-bit arithmetic: base <= a < base + size.
   function automatic int tgt_of(input logic [31:0] a);
      logic [63:0] a64;
      a64 = {32'h0, a};
      if (a64 >= {32'h0, ITCM_BASE} && a64 < {32'h0, ITCM_BASE} + {32'h0, ITCM_SIZE}) return 0;
      if (!FAULT_EN) return 1;
      if (a64 >= {32'h0, BUS_BASE} && a64 < {32'h0, BUS_BASE} + {32'h0, BUS_SIZE}) return 1;
      return 2;
   endfunction

   task automatic chk1(input string name, input bit act, input bit exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: check outputs against the model at the falling edge, then advance slaves.
   task automatic cycle();
      int          t, src, lat, due;
      bit          can, rv, ex_itcm, ex_ibus, ex_fault, ex_gnt, ex_rv, ex_err, fault_next;
      logic [31:0] ex_rd;
      ent_t        e;
      bus_t        b;
      @(negedge cpu_clk);
      cap_gnt  = fetch_gnt;  cap_rv   = fetch_rvalid; cap_rd = fetch_rdata;
      cap_err  = fetch_rerr; cap_itcm = itcm_req;     cap_ibus = ibus_req;
      t = tgt_of(fetch_addr);
      ex_itcm = 0; ex_ibus = 0; ex_fault = 0; ex_gnt = 0; ex_rv = 0; ex_err = 0; ex_rd = 32'h0;
      fault_next = 0;
      if (cpu_rst) begin
         mq.delete();
         chk1("rst_gnt", fetch_gnt, 1'b0);
         chk1("rst_itcm_req", itcm_req, 1'b0);
         chk1("rst_ibus_req", ibus_req, 1'b0);
         chk1("rst_rvalid", fetch_rvalid, 1'b0);
         chk1("rst_rerr", fetch_rerr, 1'b0);
         chk32("rst_rdata", fetch_rdata, 32'h0);
         chk32("rst_itcm_addr", itcm_addr, 32'h0);
         chk32("rst_ibus_addr", ibus_addr, 32'h0);
      end else begin
         can = (mq.size() < MAXO) && (mq.size() == 0 || mq[mq.size()-1].src == t)
               && !(t == 0 && itcm_busy);
         ex_itcm  = fetch_req && t == 0 && can;
         ex_ibus  = fetch_req && t == 1 && can;
         ex_fault = fetch_req && t == 2 && can;
         ex_gnt   = ex_itcm || (ex_ibus && ibus_gnt) || ex_fault;
         if (mq.size() > 0) begin
            src = mq[0].src;
            rv  = (src == 0) ? itcm_rvalid : (src == 1) ? ibus_rvalid : fault_pend;
            if (rv) begin
               e     = mq.pop_front();
               ex_rv = !e.stale && !fetch_flush;
               if (ex_rv) begin
                  ex_rd  = e.data;
                  ex_err = e.err;
               end
            end
         end
         if (fetch_flush) begin
            for (int i = 0; i < mq.size(); i++) mq[i].stale = 1'b1;
         end
         if (ex_gnt) begin
            e.src = t; e.data = (t == 2) ? 32'h0 : data_of(fetch_addr);
            e.err = (t == 2); e.stale = 1'b0;
            mq.push_back(e);
         end
         fault_next = ex_fault;
         chk1("gnt", fetch_gnt, ex_gnt);
         chk1("itcm_req", itcm_req, ex_itcm);
         chk1("ibus_req", ibus_req, ex_ibus);
         chk1("rvalid", fetch_rvalid, ex_rv);
         chk32("rdata", fetch_rdata, ex_rd);
         chk1("rerr", fetch_rerr, ex_err);
         chk32("itcm_addr", itcm_addr, fetch_addr);
         chk32("ibus_addr", ibus_addr, fetch_addr);
      end
      itcm_hit      = itcm_req;
      itcm_hit_addr = itcm_addr;
      if (ibus_req && ibus_gnt) begin
         lat = $urandom_range(lat_max, lat_min);
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         b.addr = ibus_addr; b.due = due;
         bq.push_back(b);
      end
      @(posedge cpu_clk);
      #1;
      cyc++;
      fault_pend  = fault_next;
      itcm_rvalid = itcm_hit;
      itcm_rdata  = itcm_hit ? data_of(itcm_hit_addr) : $urandom();
      if (bq.size() > 0 && bq[0].due <= cyc) begin
         b = bq.pop_front();
         ibus_rvalid = 1'b1;
         ibus_rdata  = data_of(b.addr);
      end else begin
         ibus_rvalid = 1'b0;
         ibus_rdata  = $urandom();
      end
   endtask

   task automatic idle_inputs();
      fetch_req = 1'b0; fetch_addr = 32'h0; fetch_flush = 1'b0;
      itcm_busy = 1'b0; ibus_gnt = 1'b1;
   endtask

   // Run idle cycles until nothing is in flight; a bounded wait.
   task automatic drain();
      int n;
      idle_inputs();
      n = 0;
      while ((mq.size() != 0 || bq.size() != 0 || itcm_rvalid || ibus_rvalid || fault_pend) && n < 60) begin
         cycle();
         n++;
      end
      chk1("drain_done", (mq.size() == 0 && bq.size() == 0), 1'b1);
   endtask

   vec_t tv[8];
   int   gcyc[5];
   int   k, rel, nrv;
   logic [31:0] rd_seen;

   initial begin
      tv[0] = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0};
      tv[1] = '{1'b1, 32'h0000_0004, 1'b0, 1'b1, 1'b1, data_of(32'h0000_0000)};
      tv[2] = '{1'b1, 32'h0000_0008, 1'b0, 1'b1, 1'b1, data_of(32'h0000_0004)};
      tv[3] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, data_of(32'h0000_0008)};
      tv[4] = '{1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 32'h0};
      tv[5] = '{1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 32'h0};
      tv[6] = '{1'b1, 32'h0000_0010, 1'b0, 1'b1, 1'b0, 32'h0};
      tv[7] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, data_of(32'h0000_0010)};

      idle_inputs();
      itcm_rvalid = 1'b0; itcm_rdata = 32'h0; ibus_rvalid = 1'b0; ibus_rdata = 32'h0;
      cpu_rst = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h0000_0004;
      #1;
      cycle();
      cycle();
      cpu_rst = 1'b0;

      // ITCM back-to-back and itcm_busy hold-off from the vector table.
      for (int i = 0; i < 8; i++) begin
         fetch_req = tv[i].req; fetch_addr = tv[i].addr; itcm_busy = tv[i].busy;
         cycle();
         chk1("tv_gnt", cap_gnt, tv[i].egnt);
         chk1("tv_itcm_req", cap_itcm, tv[i].egnt);
         chk1("tv_rvalid", cap_rv, tv[i].erv);
         chk32("tv_rdata", cap_rd, tv[i].erd);
      end
      drain();

      // Bus latency 4: fifth request stalls at the in-flight limit.
      lat_min = 4; lat_max = 4; ibus_gnt = 1'b1;
      k = 0;
      for (int i = 0; i < 5; i++) gcyc[i] = -1;
      for (int r = 0; r < 12; r++) begin
         fetch_req  = (k < 5);
         fetch_addr = 32'h0002_0000 + 32'(4 * k);
         cycle();
         if (cap_gnt && k < 5) begin
            gcyc[k] = r;
            k++;
         end
      end
      chk32("t2_4th_gnt_cycle", 32'(gcyc[3]), 32'd3);
      chk32("t2_5th_gnt_cycle", 32'(gcyc[4]), 32'd5);
      drain();

      // Bus in flight, then ITCM: held until the bus response has drained.
      fetch_req = 1'b1; fetch_addr = 32'h0002_0000;
      cycle();
      chk1("t3_bus_gnt", cap_gnt, 1'b1);
      fetch_addr = 32'h0000_0010;
      rel = -1;
      for (int r = 1; r < 12 && rel < 0; r++) begin
         cycle();
         if (cap_gnt) rel = r;
      end
      chk32("t3_itcm_gnt_cycle", 32'(rel), 32'd5);
      drain();

      // Three bus requests then a flush with a new-path request.
      for (int i = 0; i < 3; i++) begin
         fetch_req = 1'b1; fetch_addr = 32'h0002_0000 + 32'(4 * i);
         cycle();
      end
      fetch_flush = 1'b1; fetch_addr = 32'h0002_0100;
      nrv = 0; rd_seen = 32'h0;
      cycle();
      chk1("t4_flush_gnt", cap_gnt, 1'b1);
      if (cap_rv) nrv++;
      fetch_flush = 1'b0; fetch_req = 1'b0;
      for (int r = 0; r < 8; r++) begin
         cycle();
         if (cap_rv) begin
            nrv++;
            rd_seen = cap_rd;
         end
      end
      chk32("t4_delivered", 32'(nrv), 32'd1);
      chk32("t4_rdata", rd_seen, data_of(32'h0002_0100));
      drain();

      // Address outside the windows: fault with the feature, bus otherwise.
      fetch_req = 1'b1; fetch_addr = 32'hFFFF_FFF0;
      cycle();
`ifdef IMEM_ACCESS_FAULT_EN
      chk1("t6_no_ibus_req", cap_ibus, 1'b0);
      chk1("t6_gnt", cap_gnt, 1'b1);
      fetch_req = 1'b0;
      cycle();
      chk1("t6_rvalid", cap_rv, 1'b1);
      chk1("t6_rerr", cap_err, 1'b1);
      chk32("t6_rdata", cap_rd, 32'h0);
`else
      chk1("t6_ibus_req", cap_ibus, 1'b1);
      fetch_req = 1'b0;
`endif
      drain();

      // Reset with bus requests in flight: late rvalids must be ignored.
      for (int i = 0; i < 2; i++) begin
         fetch_req = 1'b1; fetch_addr = 32'h0002_0040 + 32'(4 * i);
         cycle();
      end
      cpu_rst = 1'b1;
      cycle();
      cpu_rst = 1'b0; fetch_req = 1'b0;
      nrv = 0;
      for (int r = 0; r < 6; r++) begin
         cycle();
         if (cap_rv) nrv++;
      end
      chk32("rst_late_rvalid", 32'(nrv), 32'd0);
      drain();

      // Randomized traffic across all regions.
      lat_min = 1; lat_max = 5;
      for (int r = 0; r < 2000; r++) begin
         fetch_req   = ($urandom_range(3, 0) != 0);
         case ($urandom_range(2, 0))
            0:       fetch_addr = {16'h0, 16'($urandom_range(16383, 0) * 4)};
            1:       fetch_addr = 32'h0002_0000 + 32'($urandom_range(1023, 0) * 4);
            default: fetch_addr = 32'hFFFF_FF00 + 32'($urandom_range(63, 0) * 4);
         endcase
         fetch_flush = ($urandom_range(15, 0) == 0);
         itcm_busy   = ($urandom_range(6, 0) == 0);
         ibus_gnt    = ($urandom_range(3, 0) != 0);
         cycle();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
